cpu_memory_stage: RTL and testbench

Memory-access pipeline stage sitting between execute and commit. Non-memory operations pass straight through a one-cycle pipeline register. Loads and stores are issued to the data-memory port through a valid/ready request and response handshake, and the upstream pipeline is stalled until each access completes. The registered result, destination register and register-write flag are presented to the commit stage.

---
 rtl/cpu_memory_stage_if.sv | 25 ++
 rtl/cpu_memory_stage.sv | 156 +++++++++++++++
 tb/tb_cpu_memory_stage.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_memory_stage_if.sv
`timescale 1ns/1ps
// Data-memory request/response bus between the memory stage (master) and the data memory (slave).
interface cpu_memory_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    dmem_req_valid;
    logic                    dmem_req_ready;
    logic [ADDR_WIDTH-1:0]   dmem_req_addr;
    logic                    dmem_req_we;
    logic [DATA_WIDTH-1:0]   dmem_req_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_req_be;
    logic                    dmem_resp_valid;
    logic [DATA_WIDTH-1:0]   dmem_resp_rdata;

    modport master (
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_be,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_be,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata
    );
endinterface

// File: rtl/cpu_memory_stage.sv
`timescale 1ns/1ps
// Memory-access stage: ALU ops pass through one register; loads/stores run a
// valid/ready request (and a response for loads) while the upstream pipeline is stalled.
module cpu_memory_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_dest,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      ex_mem_byte,
    output logic                      mem_stall,
    cpu_memory_stage_if.master        dmem,
    output logic                      commit_valid,
    output logic [DATA_WIDTH-1:0]     commit_result,
    output logic [REG_ADDR_WIDTH-1:0] commit_reg_dest,
    output logic                      commit_reg_write
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                    state_q;
    logic [DATA_WIDTH-1:0]     op_addr_q;
    logic [REG_ADDR_WIDTH-1:0] op_dest_q;
    logic                      op_regw_q;
    logic                      op_byte_q;

    logic                      req_valid_q;
    logic [ADDR_WIDTH-1:0]     req_addr_q;
    logic                      req_we_q;
    logic [DATA_WIDTH-1:0]     req_wdata_q;
    logic [LANES-1:0]          req_be_q;

    logic                      commit_valid_q;
    logic [DATA_WIDTH-1:0]     commit_result_q;
    logic [REG_ADDR_WIDTH-1:0] commit_dest_q;
    logic                      commit_regw_q;

    logic                      mem_op_d;
    logic [ADDR_WIDTH-1:0]     ex_addr_d;
    logic [ADDR_WIDTH-1:0]     req_addr_d;
    logic [LB-1:0]             lane_d;

    function automatic logic [LANES-1:0] lane_enable(input logic byte_acc, input logic [LB-1:0] k);
        logic [LANES-1:0] be;
        be    = '0;
        be[k] = 1'b1;
        return byte_acc ? be : '1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic byte_acc,
                                                         input logic [DATA_WIDTH-1:0] d);
        return byte_acc ? {LANES{d[7:0]}} : d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_format(input logic byte_acc,
                                                          input logic [LB-1:0] k,
                                                          input logic [DATA_WIDTH-1:0] rd);
        logic [DATA_WIDTH-1:0] sh;
        sh = rd >> {k, 3'b000};
        return byte_acc ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} : rd;
    endfunction

    // Word accesses are naturally aligned by clearing the lane bits; byte accesses keep them.
    assign mem_op_d   = ex_mem_read | ex_mem_write;
    assign ex_addr_d  = ex_alu_result[ADDR_WIDTH-1:0];
    assign lane_d     = ex_alu_result[LB-1:0];
    assign req_addr_d = ex_mem_byte ? ex_addr_d : {ex_addr_d[ADDR_WIDTH-1:LB], {LB{1'b0}}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            op_addr_q       <= '0;
            op_dest_q       <= '0;
            op_regw_q       <= 1'b0;
            op_byte_q       <= 1'b0;
            req_valid_q     <= 1'b0;
            req_addr_q      <= '0;
            req_we_q        <= 1'b0;
            req_wdata_q     <= '0;
            req_be_q        <= '0;
            commit_valid_q  <= 1'b0;
            commit_result_q <= '0;
            commit_dest_q   <= '0;
            commit_regw_q   <= 1'b0;
        end else begin
            commit_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ex_valid && mem_op_d) begin
                        op_addr_q   <= ex_alu_result;
                        op_dest_q   <= ex_reg_dest;
                        op_regw_q   <= ex_reg_write;
                        op_byte_q   <= ex_mem_byte;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= req_addr_d;
                        req_we_q    <= ex_mem_write;
                        req_wdata_q <= lane_wdata(ex_mem_byte, ex_store_data);
                        req_be_q    <= lane_enable(ex_mem_byte, lane_d);
                        state_q     <= REQ;
                    end else if (ex_valid) begin
                        commit_valid_q  <= 1'b1;
                        commit_result_q <= ex_alu_result;
                        commit_dest_q   <= ex_reg_dest;
                        commit_regw_q   <= ex_reg_write;
                    end
                end
                REQ: begin
                    // Stores complete on acceptance and report their address; loads await data.
                    if (dmem.dmem_req_ready) begin
                        req_valid_q <= 1'b0;
                        if (req_we_q) begin
                            commit_valid_q  <= 1'b1;
                            commit_result_q <= op_addr_q;
                            commit_dest_q   <= op_dest_q;
                            commit_regw_q   <= op_regw_q;
                            state_q         <= IDLE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.dmem_resp_valid) begin
                        commit_valid_q  <= 1'b1;
                        commit_result_q <= load_format(op_byte_q, op_addr_q[LB-1:0], dmem.dmem_resp_rdata);
                        commit_dest_q   <= op_dest_q;
                        commit_regw_q   <= op_regw_q;
                        state_q         <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_stall           = (state_q != IDLE);
    assign dmem.dmem_req_valid = req_valid_q;
    assign dmem.dmem_req_addr  = req_addr_q;
    assign dmem.dmem_req_we    = req_we_q;
    assign dmem.dmem_req_wdata = req_wdata_q;
    assign dmem.dmem_req_be    = req_be_q;
    assign commit_valid        = commit_valid_q;
    assign commit_result       = commit_result_q;
    assign commit_reg_dest     = commit_dest_q;
    assign commit_reg_write    = commit_regw_q;
endmodule

// File: tb/tb_cpu_memory_stage.sv
`timescale 1ns/1ps
// Bench for cpu_memory_stage: directed vector table, reset/spurious-response sequences,
// then randomized traffic against a transaction-level model.
module tb_cpu_memory_stage;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_byte;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_reg_dest;
  logic        mem_stall, commit_valid, commit_reg_write;
  logic [31:0] commit_result;
  logic [4:0]  commit_reg_dest;

  cpu_memory_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dif ();

  cpu_memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_reg_dest(ex_reg_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_byte(ex_mem_byte), .mem_stall(mem_stall),
    .dmem(dif), .commit_valid(commit_valid), .commit_result(commit_result),
    .commit_reg_dest(commit_reg_dest), .commit_reg_write(commit_reg_write)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (act=running req=finished)");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store
  task automatic drive(input logic ev, input int kind, input logic [31:0] alu, sd,
                       input logic [4:0] rd, input logic rw, by, rdy, rv,
                       input logic [31:0] rdata);
    ex_valid = ev; ex_alu_result = alu; ex_store_data = sd; ex_reg_dest = rd;
    ex_reg_write = rw; ex_mem_read = (kind == 1); ex_mem_write = (kind == 2);
    ex_mem_byte = by; dif.dmem_req_ready = rdy; dif.dmem_resp_valid = rv;
    dif.dmem_resp_rdata = rdata;
  endtask

  typedef struct {
    logic ev; int kind; logic [31:0] alu, sd; logic [4:0] rd; logic rw, by, rdy, rv;
    logic [31:0] rdata;
    logic cv; logic [31:0] cres; logic [4:0] cdest; logic cregw; logic stall;
    logic qv; logic [31:0] qaddr; logic [3:0] qbe; logic [31:0] qwd; logic qwe;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic ev, input int kind, input logic [31:0] alu, sd,
                     input logic [4:0] rd, input logic rw, by, rdy, rv, input logic [31:0] rdata,
                     input logic cv, input logic [31:0] cres, input logic [4:0] cdest,
                     input logic cregw, stall, qv, input logic [31:0] qaddr,
                     input logic [3:0] qbe, input logic [31:0] qwd, input logic qwe);
    vec_t v;
    v.ev = ev; v.kind = kind; v.alu = alu; v.sd = sd; v.rd = rd; v.rw = rw; v.by = by;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.cv = cv; v.cres = cres; v.cdest = cdest;
    v.cregw = cregw; v.stall = stall; v.qv = qv; v.qaddr = qaddr; v.qbe = qbe;
    v.qwd = qwd; v.qwe = qwe;
    vecs.push_back(v);
  endtask

  // Transaction-level reference for the random phase
  typedef struct { logic [31:0] res; logic [4:0] rd; logic rw; } cm_t;
  cm_t expq[$];
  logic        busy = 0, req_done = 0, waiting = 0;
  int          cnt = 0;
  int          fl_kind;
  logic [31:0] fl_a, fl_sd, fl_rdata;
  logic [4:0]  fl_rd;
  logic        fl_rw, fl_by;

  function automatic logic [31:0] ref_load(input logic by, input logic [31:0] a, rd);
    if (!by) return rd;
    return (rd >> (8 * (a % 4))) & 32'hFF;
  endfunction

  task automatic rnd_check();
    cm_t e;
    chk("rnd_commit_valid", 32'(commit_valid), 32'(expq.size() != 0));
    if (commit_valid && expq.size() != 0) begin
      e = expq.pop_front();
      chk("rnd_commit_result", commit_result, e.res);
      chk("rnd_commit_dest", 32'(commit_reg_dest), 32'(e.rd));
      chk("rnd_commit_regw", 32'(commit_reg_write), 32'(e.rw));
    end
    chk("rnd_stall", 32'(mem_stall), 32'(busy));
    chk("rnd_req_valid", 32'(dif.dmem_req_valid), 32'(busy && !req_done));
    if (busy && !req_done) begin
      chk("rnd_req_addr", dif.dmem_req_addr, fl_by ? fl_a : (fl_a & ~32'h3));
      chk("rnd_req_be", 32'(dif.dmem_req_be), fl_by ? (32'd1 << (fl_a % 4)) : 32'hF);
      chk("rnd_req_wdata", dif.dmem_req_wdata, fl_by ? (fl_sd & 32'hFF) * 32'h01010101 : fl_sd);
      chk("rnd_req_we", 32'(dif.dmem_req_we), 32'(fl_kind == 2));
    end
  endtask

  initial begin
    logic        have_op, ex_acc, req_acc, resp_now, rdy, rv;
    int          c_kind;
    logic [31:0] c_a, c_sd, c_rdata, rdat;
    logic [4:0]  c_rd;
    logic        c_rw, c_by;
    cm_t         e;

    // Reset held: every output must read zero despite active inputs.
    drive(1, 1, 32'h1234, 32'h5678, 5'd3, 1, 0, 1, 1, 32'hFFFF_FFFF);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_commit_result", commit_result, 0);
    chk("rst_commit_dest", 32'(commit_reg_dest), 0);
    chk("rst_commit_regw", 32'(commit_reg_write), 0);
    chk("rst_mem_stall", 32'(mem_stall), 0);
    chk("rst_req_valid", 32'(dif.dmem_req_valid), 0);
    chk("rst_req_addr", dif.dmem_req_addr, 0);
    chk("rst_req_wdata", dif.dmem_req_wdata, 0);
    chk("rst_req_be", 32'(dif.dmem_req_be), 0);
    chk("rst_req_we", 32'(dif.dmem_req_we), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Pass-through of three ALU ops, then idle
    add(1,0,32'h11,0,1,1,0, 0,0,0, 1,32'h11,1,1, 0, 0,0,0,0,0);
    add(1,0,32'h22,0,2,1,0, 0,0,0, 1,32'h22,2,1, 0, 0,0,0,0,0);
    add(1,0,32'h33,0,3,1,0, 0,0,0, 1,32'h33,3,1, 0, 0,0,0,0,0);
    add(0,0,0,0,0,0,0,      0,0,0, 0,0,0,0,      0, 0,0,0,0,0);
    // Word load at 0x1003: two ready-low cycles, response three cycles after accept
    add(1,1,32'h1003,0,7,1,0, 0,0,0, 0,0,0,0, 1, 1,32'h1000,4'hF,0,0);
    add(1,1,32'h1003,0,7,1,0, 0,0,0, 0,0,0,0, 1, 1,32'h1000,4'hF,0,0);
    add(1,1,32'h1003,0,7,1,0, 0,0,0, 0,0,0,0, 1, 1,32'h1000,4'hF,0,0);
    add(1,1,32'h1003,0,7,1,0, 1,0,0, 0,0,0,0, 1, 0,0,0,0,0);
    add(1,1,32'h1003,0,7,1,0, 0,0,0, 0,0,0,0, 1, 0,0,0,0,0);
    add(1,1,32'h1003,0,7,1,0, 0,0,0, 0,0,0,0, 1, 0,0,0,0,0);
    add(1,1,32'h1003,0,7,1,0, 0,1,32'hDEADBEEF, 1,32'hDEADBEEF,7,1, 0, 0,0,0,0,0);
    add(0,0,0,0,0,0,0, 0,1,32'h5555, 0,0,0,0, 0, 0,0,0,0,0);
    // Byte store at 0x2002, then byte load at 0x2001
    add(1,2,32'h2002,32'h123456AB,0,0,1, 1,0,0, 0,0,0,0, 1, 1,32'h2002,4'h4,32'hABABABAB,1);
    add(1,2,32'h2002,32'h123456AB,0,0,1, 1,0,0, 1,32'h2002,0,0, 0, 0,0,0,0,0);
    add(1,1,32'h2001,0,9,1,1, 0,0,0, 0,0,0,0, 1, 1,32'h2001,4'h2,0,0);
    add(1,1,32'h2001,0,9,1,1, 1,0,0, 0,0,0,0, 1, 0,0,0,0,0);
    add(1,1,32'h2001,0,9,1,1, 0,1,32'hAABBCCDD, 1,32'hCC,9,1, 0, 0,0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0, 0,0,0,0,0);
    // Load then store back-to-back; store is held by mem_stall until the load commits
    add(1,1,32'h3000,0,4,1,0, 1,0,0, 0,0,0,0, 1, 1,32'h3000,4'hF,0,0);
    add(1,2,32'h3010,32'hCAFEF00D,6,0,0, 1,0,0, 0,0,0,0, 1, 0,0,0,0,0);
    add(1,2,32'h3010,32'hCAFEF00D,6,0,0, 1,1,32'h01020304, 1,32'h01020304,4,1, 0, 0,0,0,0,0);
    add(1,2,32'h3010,32'hCAFEF00D,6,0,0, 1,0,0, 0,0,0,0, 1, 1,32'h3010,4'hF,32'hCAFEF00D,1);
    add(1,2,32'h3010,32'hCAFEF00D,6,0,0, 1,0,0, 1,32'h3010,6,0, 0, 0,0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0, 0,0,0,0,0);

    @(posedge clock);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ev, vecs[i].kind, vecs[i].alu, vecs[i].sd, vecs[i].rd, vecs[i].rw,
            vecs[i].by, vecs[i].rdy, vecs[i].rv, vecs[i].rdata);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_commit_valid", i), 32'(commit_valid), 32'(vecs[i].cv));
      chk($sformatf("vec%0d_stall", i), 32'(mem_stall), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_req_valid", i), 32'(dif.dmem_req_valid), 32'(vecs[i].qv));
      if (vecs[i].cv) begin
        chk($sformatf("vec%0d_commit_result", i), commit_result, vecs[i].cres);
        chk($sformatf("vec%0d_commit_dest", i), 32'(commit_reg_dest), 32'(vecs[i].cdest));
        chk($sformatf("vec%0d_commit_regw", i), 32'(commit_reg_write), 32'(vecs[i].cregw));
      end
      if (vecs[i].qv) begin
        chk($sformatf("vec%0d_req_addr", i), dif.dmem_req_addr, vecs[i].qaddr);
        chk($sformatf("vec%0d_req_be", i), 32'(dif.dmem_req_be), 32'(vecs[i].qbe));
        chk($sformatf("vec%0d_req_wdata", i), dif.dmem_req_wdata, vecs[i].qwd);
        chk($sformatf("vec%0d_req_we", i), 32'(dif.dmem_req_we), 32'(vecs[i].qwe));
      end
    end

    // Reset asserted while waiting for a load response, then a late response
    drive(1, 1, 32'h40, 0, 5'd5, 1, 0, 1, 0, 0);
    @(posedge clock); #1;
    chk("rw_req_valid", 32'(dif.dmem_req_valid), 1);
    @(posedge clock); #1;
    chk("rw_wait_stall", 32'(mem_stall), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rw_async_stall", 32'(mem_stall), 0);
    chk("rw_async_req_valid", 32'(dif.dmem_req_valid), 0);
    chk("rw_async_result", commit_result, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    @(posedge clock); #1;
    chk("rw_late_resp_commit", 32'(commit_valid), 0);
    chk("rw_late_resp_stall", 32'(mem_stall), 0);

    // Reset asserted while a store request is outstanding
    drive(1, 2, 32'h80, 32'h99, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("rr_req_valid", 32'(dif.dmem_req_valid), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rr_async_req_valid", 32'(dif.dmem_req_valid), 0);
    chk("rr_async_req_addr", dif.dmem_req_addr, 0);
    chk("rr_async_req_we", 32'(dif.dmem_req_we), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rr_after_commit", 32'(commit_valid), 0);
    chk("rr_after_stall", 32'(mem_stall), 0);

    // Randomized traffic against the reference model
    have_op = 0;
    c_kind = 0; c_a = 0; c_sd = 0; c_rdata = 0; c_rd = 0; c_rw = 0; c_by = 0;
    for (int i = 0; i < 3000; i++) begin
      rnd_check();
      if (!have_op && $urandom_range(0, 3) != 0) begin
        have_op = 1;
        c_kind  = int'($urandom_range(0, 2));
        c_a     = $urandom;
        c_sd    = $urandom;
        c_rdata = $urandom;
        c_rd    = 5'($urandom_range(0, 31));
        c_rw    = 1'($urandom_range(0, 1));
        c_by    = (c_kind != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      rdy = ($urandom_range(0, 2) != 0);
      if (waiting) begin
        rv = (cnt == 1);
        if (cnt > 1) cnt--;
        rdat = fl_rdata;
      end else begin
        rv = ($urandom_range(0, 7) == 0);
        rdat = $urandom;
      end
      drive(have_op, c_kind, c_a, c_sd, c_rd, c_rw, c_by, rdy, rv, rdat);
      ex_acc   = have_op && !busy;
      req_acc  = busy && !req_done && rdy;
      resp_now = waiting && rv;
      @(posedge clock); #1;
      if (resp_now) begin
        e.res = ref_load(fl_by, fl_a, fl_rdata); e.rd = fl_rd; e.rw = fl_rw;
        expq.push_back(e);
        busy = 0; waiting = 0;
      end
      if (req_acc) begin
        req_done = 1;
        if (fl_kind == 2) begin
          e.res = fl_a; e.rd = fl_rd; e.rw = fl_rw;
          expq.push_back(e);
          busy = 0;
        end else begin
          waiting = 1;
          cnt = int'($urandom_range(1, 3));
        end
      end
      if (ex_acc) begin
        have_op = 0;
        if (c_kind == 0) begin
          e.res = c_a; e.rd = c_rd; e.rw = c_rw;
          expq.push_back(e);
        end else begin
          busy = 1; req_done = 0;
          fl_kind = c_kind; fl_a = c_a; fl_sd = c_sd; fl_rdata = c_rdata;
          fl_rd = c_rd; fl_rw = c_rw; fl_by = c_by;
        end
      end
    end
    rnd_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
